// File: rtl/shift_left_pkg.sv
// Shared definitions for the shift_left registered shifter/rotator.
//   WIDTH_DEFAULT : default operand/result width
//   mode_e        : shift mode encoding applied to the rotate input
//   carry_of      : reference carry-out for an operand/width/shift amount
package shift_left_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic {
    MODE_LSL = 1'b0,
    MODE_ROL = 1'b1
  } mode_e;

  // Last bit leaving the MSB end; zero when nothing leaves (shamt = 0)
  // and for out-of-range amounts (shamt >= width).
  function automatic logic carry_of(input logic [63:0] data,
                                    input int unsigned width,
                                    input int unsigned shamt);
    if (shamt == 0 || shamt >= width) begin
      return 1'b0;
    end
    return data[width - shamt];
  endfunction

endpackage

// File: rtl/shift_left_stage.sv
// One barrel stage: shifts or rotates left by STAGE_SHIFT when enabled.
//   data     : stage input
//   enable   : apply this stage's shift
//   rotate   : 0 = zero fill, 1 = wrap MSBs into LSBs
//   data_out : stage output
//   bit_out  : last bit leaving the MSB end (0 when disabled)
module shift_left_stage
  import shift_left_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEFAULT,
  parameter int unsigned STAGE_SHIFT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic             rotate,
  output logic [WIDTH-1:0] data_out,
  output logic             bit_out
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] rotated;

  assign shifted = {data[WIDTH-STAGE_SHIFT-1:0], {STAGE_SHIFT{1'b0}}};
  assign rotated = {data[WIDTH-STAGE_SHIFT-1:0], data[WIDTH-1:WIDTH-STAGE_SHIFT]};

  always_comb begin
    data_out = data;
    bit_out  = 1'b0;
    if (enable) begin
      data_out = (mode_e'(rotate) == MODE_ROL) ? rotated : shifted;
      bit_out  = data[WIDTH-STAGE_SHIFT];
    end
  end

endmodule

// File: rtl/shift_left.sv
// Registered left shifter/rotator with a one-cycle valid pipeline.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : operand/controls valid this cycle
//   n1        : operand
//   shamt     : shift amount
//   rotate    : 0 = logical shift left, 1 = rotate left
//   out_valid : result/carry_out valid
//   result    : shifted/rotated operand (held while out_valid = 0)
//   carry_out : last bit shifted off the MSB end (held while out_valid = 0)
module shift_left
  import shift_left_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEFAULT,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   n1,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               rotate,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out
);

  logic [WIDTH-1:0] stage_data  [SHAMT_W+1];
  logic             stage_carry [SHAMT_W+1];
  logic             carry_d;

  assign stage_data[0]  = n1;
  assign stage_carry[0] = 1'b0;

  // The carry is taken from the highest enabled stage: its input has already
  // been moved by the lower stages, so the bit it spills is n1[WIDTH-shamt]
  // in both modes for any in-range amount.
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    logic spill;

    shift_left_stage #(
      .WIDTH       (WIDTH),
      .STAGE_SHIFT (2 ** i)
    ) u_stage (
      .data     (stage_data[i]),
      .enable   (shamt[i]),
      .rotate   (rotate),
      .data_out (stage_data[i+1]),
      .bit_out  (spill)
    );

    assign stage_carry[i+1] = shamt[i] ? spill : stage_carry[i];
  end

  // Out-of-range amounts (non power-of-2 WIDTH only) never report a carry.
  always_comb begin
    carry_d = 1'b0;
    if (int'(shamt) < int'(WIDTH)) begin
      carry_d = stage_carry[SHAMT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result    <= stage_data[SHAMT_W];
        carry_out <= carry_d;
      end
    end
  end

endmodule

// File: tb/tb_shift_left.sv
module tb_shift_left;

  typedef struct {
    logic       valid;
    logic [3:0] res;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] n1;
  logic [1:0] shamt;
  logic       rotate;
  logic       out_valid;
  logic [3:0] result;
  logic       carry_out;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] held_res = '0;
  logic       held_c   = 1'b0;

  shift_left #(.WIDTH(4), .SHAMT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .n1        (n1),
    .shamt     (shamt),
    .rotate    (rotate),
    .out_valid (out_valid),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per clock edge, checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (out_valid !== e.valid) begin
          n_bad++;
          $display("FAIL out_valid: got %b expected %b at %0t", out_valid, e.valid, $time);
        end
        n_cmp++;
        if (result !== e.res) begin
          n_bad++;
          $display("FAIL result: got %b expected %b at %0t", result, e.res, $time);
        end
        n_cmp++;
        if (carry_out !== e.c) begin
          n_bad++;
          $display("FAIL carry_out: got %b expected %b at %0t", carry_out, e.c, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [3:0] a, input logic [1:0] sh, input logic rot,
                     input logic [3:0] er, input logic ec);
    exp_t e;
    rst = 1'b0; in_valid = 1'b1; n1 = a; shamt = sh; rotate = rot;
    e.valid = 1'b1; e.res = er; e.c = ec;
    held_res = er; held_c = ec;
    sb.push_back(e);
    tick();
  endtask

  task automatic idle();
    exp_t e;
    rst = 1'b0; in_valid = 1'b0; n1 = 4'hF; shamt = 2'd3; rotate = 1'b1;
    e.valid = 1'b0; e.res = held_res; e.c = held_c;
    sb.push_back(e);
    tick();
  endtask

  task automatic reset_cycle(input logic [3:0] a);
    exp_t e;
    rst = 1'b1; in_valid = 1'b1; n1 = a; shamt = 2'd1; rotate = 1'b0;
    e.valid = 1'b0; e.res = 4'b0000; e.c = 1'b0;
    held_res = '0; held_c = 1'b0;
    sb.push_back(e);
    tick();
  endtask

  initial begin
    logic [3:0] v;
    int         waits;

    // Reset held two cycles with a valid operand that must be dropped.
    reset_cycle(4'b1111);
    reset_cycle(4'b1111);

    // Logical shift-by-one sweep, back to back.
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      txn(v, 2'd1, 1'b0, {v[2:0], 1'b0}, v[3]);
    end

    // Rotate mode.
    txn(4'b1001, 2'd1, 1'b1, 4'b0011, 1'b1);
    txn(4'b0110, 2'd3, 1'b1, 4'b0011, 1'b1);
    txn(4'b1000, 2'd2, 1'b1, 4'b0010, 1'b0);
    txn(4'b0100, 2'd2, 1'b1, 4'b0001, 1'b1);

    // Boundary amounts.
    txn(4'b1010, 2'd0, 1'b0, 4'b1010, 1'b0);
    txn(4'b1010, 2'd0, 1'b1, 4'b1010, 1'b0);
    txn(4'b0111, 2'd3, 1'b0, 4'b1000, 1'b1);
    txn(4'b1101, 2'd2, 1'b0, 4'b0100, 1'b1);
    txn(4'b0101, 2'd3, 1'b0, 4'b1000, 1'b0);

    // Valid gaps: outputs hold while in_valid is low.
    txn(4'b0001, 2'd1, 1'b0, 4'b0010, 1'b0);
    idle();
    idle();
    txn(4'b0010, 2'd1, 1'b0, 4'b0100, 1'b0);

    // Reset between two valid operands.
    txn(4'b1011, 2'd1, 1'b0, 4'b0110, 1'b1);
    reset_cycle(4'b1111);
    txn(4'b0101, 2'd1, 1'b0, 4'b1010, 1'b0);
    idle();

    // Drain the scoreboard with a bounded wait.
    waits = 0;
    while (sb.size() != 0 && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
